instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields (op, funct5, register indices, immediate) into 19-bit instruction words and streams them into the instruction memory write port at consecutive addresses. It is the encode/write side of the instruction path whose decode/read side is the CPU controller: the testbench host or boot loader drives fields in, and the CPU later fetches the packed words. A 2-entry output buffer decouples the field handshake from memory write stalls.

## Interface
- `AW`, 8: instruction memory address width; capacity 2^AW words.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: clear address, flags, counter; enter RUN.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder accepts bundle this cycle.
- `op`  in  5  opcode.
- `funct5`  in  5  function field; bit 4 is the f7b5 bit seen by the ALU decoder.
- `rd`, `rs1`, `rs2`  in  3 each  register indices.
- `imm`  in  11  signed immediate.
- `im_we`  out  1  write strobe; stays high until `im_ready`.
- `im_ready`  in  1  memory accepts write.
- `im_addr`  out  AW  write address.
- `im_wdata`  out  19  packed word.
- `full`  out  1  last address written; no further writes.
- `err`  out  1  sticky: a bundle was rejected.
- `err_count`  out  8  rejected bundles, saturating at 255.

## Operation
- States: IDLE, RUN, FULL. Reset → IDLE. `start` in any state → RUN with next address 0, buffer flushed, `err`/`err_count`/`full` cleared.
- `in_ready` = (state==RUN) && buffer not full && no allocation pending for the last address.
- Format is selected from `op` by the package lookup. Bit layout (`[4:0]` op in all formats):
  - R: `[7:5]` rd, `[12:8]` funct5, `[15:13]` rs1, `[18:16]` rs2.
  - I: `[7:5]` rd, `[12:8]` funct5, `[15:13]` rs1, `[18:16]` imm[2:0].
  - B: `[7:5]` rs2, `[12:8]` imm[4:0], `[15:13]` rs1, `[18:16]` 0.
  - J: `[7:5]` rd, `[18:8]` imm[10:0].
- Immediate range, signed: I −4..3, B −16..15, J full 11 bits. Fields unused by a format are ignored.
- Rejection: unknown op, or immediate out of range. The bundle is consumed (handshake completes) but not buffered and no address is consumed. `err` is set; `err_count` is incremented and saturates at 255.
- Accepted word: enqueued with address = next address; the next address is then incremented.
- Enqueuing address 2^AW−1 moves the state to FULL once that word drains. No address wrap.
- Buffer head is presented on `im_*`; it pops on `im_we && im_ready`.
- Simultaneous push and pop while the buffer holds 2 entries is not possible, because `in_ready` is low.

## Timing
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `full`=0, `err`=0, `err_count`=0.
- Latency: a bundle accepted at edge N into an empty buffer gives `im_we`=1 in cycle N+1.
- Throughput: one word per cycle while `im_ready`=1.
- `im_addr` and `im_wdata` are held stable while `im_we && !im_ready`.
- `start` takes priority over a same-cycle handshake; that bundle is dropped.
- Reset mid-operation discards buffered words; no partial write is issued.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined: immediate range check active, with rejection as above.
- Not defined: immediates are truncated to the field width with no check. Only an unknown op rejects a bundle.

## Structure
- Shared package `cpu19_pkg` holds:
  - opcode constants and the `fmt_t` enum {FMT_R, FMT_I, FMT_B, FMT_J}, encoded to match the controller's immsrc;
  - function `op_to_fmt` (returns a valid bit plus the format);
  - field bit-position constants;
  - the `enc_state_t` enum.
- One sub-module, `enc_fifo2`: a 2-entry buffer, (AW+19) bits wide, with push, pop, full, empty and head.

## Test plan
- `start`, then an R-op with rd=1 funct5=0x10 rs1=2 rs2=3, `im_ready`=1 → `im_addr`=0; word fields: op, rd=1 at [7:5], funct5=0x10 at [12:8], rs1=2 at [15:13], rs2=3 at [18:16].
- I-op with imm=4 and the macro defined → no write, `err`=1, `err_count`=1, next accepted word lands at `im_addr`=0. Macro undefined → written with imm field 3'b100.
- `im_ready` held low 5 cycles during a 3-bundle burst → `in_ready` drops after 2 accepts, `im_addr`/`im_wdata` stable, words emerge in order at addresses 0, 1, 2.
- AW=2: stream 5 valid bundles → addresses 0–3 written, `full`=1, `in_ready`=0, 5th bundle never accepted.
- Assert `reset_n`=0 with 2 words buffered → all outputs return to reset values immediately. `start` then resumes at address 0.
- J-op with imm=−1024 → bits [18:8] = 11'h400. 256 illegal ops → `err_count` saturates at 255.

Source files
------------

// File: rtl/cpu19_pkg.sv
// cpu19_pkg: definitions shared by the 19-bit instruction path.
// The encoder (write side) and the CPU controller (read side) both use it.
//   - opcode constants, and the fmt_t instruction-format enum
//   - op_to_fmt: opcode -> {valid, format}
//   - bit positions of the fields in the packed word
//   - enc_state_t, the state enum of instr_encoder
package cpu19_pkg;

    localparam int WORD_W = 19;

    // Opcodes. Any other value is an unknown op.
    localparam logic [4:0] OP_LOAD   = 5'h00;  // I format
    localparam logic [4:0] OP_ALUI   = 5'h04;  // I format
    localparam logic [4:0] OP_ALU    = 5'h0C;  // R format
    localparam logic [4:0] OP_BRANCH = 5'h18;  // B format
    localparam logic [4:0] OP_JAL    = 5'h1B;  // J format

    // The encoding matches the controller's immsrc: I=00, B=10, J=11.
    // The R format carries no immediate, so it takes the spare code 01.
    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_R = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_t;

    typedef struct packed {
        logic valid;
        fmt_t fmt;
    } fmt_info_t;

    // Least-significant bit of each field in the packed word.
    localparam int OP_LSB   = 0;   // [4:0] in every format
    localparam int RD_LSB   = 5;   // R/I/J rd; in B this slot holds rs2
    localparam int F5_LSB   = 8;   // R/I funct5; in B this slot holds imm[4:0]
    localparam int RS1_LSB  = 13;  // R/I/B rs1
    localparam int RS2_LSB  = 16;  // R rs2; in I this slot holds imm[2:0]
    localparam int JIMM_LSB = 8;   // J imm[10:0] occupies [18:8]

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } enc_state_t;

    function automatic fmt_info_t op_to_fmt(input logic [4:0] op);
        fmt_info_t r;
        r.valid = 1'b1;
        r.fmt   = FMT_R;
        case (op)
            OP_ALU:           r.fmt = FMT_R;
            OP_LOAD, OP_ALUI: r.fmt = FMT_I;
            OP_BRANCH:        r.fmt = FMT_B;
            OP_JAL:           r.fmt = FMT_J;
            default:          r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo2: a two-entry FIFO that sits between the encoder and the
// instruction-memory write port.
// Ports:
//   clk, reset_n   clock, and an asynchronous active-low reset
//   flush          synchronous clear. It wins over push and pop.
//   push, wdata    enqueue. Ignored when the FIFO is full.
//   pop            dequeue. Ignored when the FIFO is empty.
//   full, empty    occupancy flags
//   head           oldest entry. Reset clears the storage, so head is 0 out of reset.
module enc_fifo2 #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign head    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 19-bit words. It
// writes the words to the instruction memory at consecutive addresses.
// Build option: define INSTR_ENC_RANGE_CHECK_EN to reject an I or B
// immediate that does not fit its field. Without it, the immediate is
// truncated to the field width.
// Handshakes: a bundle transfers on a rising edge where in_valid and in_ready are both high.
// A memory write completes on a rising edge where im_we and im_ready are both high.
// im_addr and im_wdata hold steady while im_we is high and im_ready is low.
// Ports:
//   clk, reset_n        clock, and an asynchronous active-low reset
//   start               pulse: enter RUN at address 0, clear the flags and the buffer
//   in_valid, in_ready  field-bundle handshake
//   op, funct5, rd, rs1, rs2, imm   the decoded fields. funct5[4] is the ALU's f7b5 bit.
//   im_we, im_ready, im_addr, im_wdata   memory write port
//   full                last address written
//   err, err_count      sticky reject flag, and a saturating count of rejects
//   dbg_state           current FSM state
module instr_encoder
    import cpu19_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    op,
    input  logic [4:0]    funct5,
    input  logic [2:0]    rd,
    input  logic [2:0]    rs1,
    input  logic [2:0]    rs2,
    input  logic [10:0]   imm,
    output logic          im_we,
    input  logic          im_ready,
    output logic [AW-1:0] im_addr,
    output logic [18:0]   im_wdata,
    output logic          full,
    output logic          err,
    output logic [7:0]    err_count,
    output enc_state_t    dbg_state
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    enc_state_t           state;
    logic [AW-1:0]        next_addr;
    logic                 last_alloc;  // address 2^AW-1 has been handed out
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AW+WORD_W-1:0] fifo_head;
    fmt_info_t            fi;
    logic                 imm_ok;
    logic [WORD_W-1:0]    word;
    logic                 hs;
    logic                 push;

    assign fi       = op_to_fmt(op);
    assign in_ready = (state == ST_RUN) && !fifo_full && !last_alloc;
    // A start pulse drops any bundle that transfers in the same cycle.
    assign hs       = in_valid && in_ready && !start;
    assign push     = hs && fi.valid && imm_ok;

    always_comb begin
        imm_ok = 1'b1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        // The immediate fits when every bit above the field repeats the field's sign bit.
        case (fi.fmt)
            FMT_I:   imm_ok = (imm[10:2] == {9{imm[2]}});
            FMT_B:   imm_ok = (imm[10:4] == {7{imm[4]}});
            default: imm_ok = 1'b1;
        endcase
`endif
    end

    always_comb begin
        word = '0;
        word[OP_LSB +: 5] = op;
        case (fi.fmt)
            FMT_R: begin
                word[RD_LSB  +: 3] = rd;
                word[F5_LSB  +: 5] = funct5;
                word[RS1_LSB +: 3] = rs1;
                word[RS2_LSB +: 3] = rs2;
            end
            FMT_I: begin
                word[RD_LSB  +: 3] = rd;
                word[F5_LSB  +: 5] = funct5;
                word[RS1_LSB +: 3] = rs1;
                word[RS2_LSB +: 3] = imm[2:0];
            end
            FMT_B: begin
                word[RD_LSB  +: 3] = rs2;
                word[F5_LSB  +: 5] = imm[4:0];
                word[RS1_LSB +: 3] = rs1;
            end
            default: begin
                word[RD_LSB   +: 3]  = rd;
                word[JIMM_LSB +: 11] = imm;
            end
        endcase
    end

    enc_fifo2 #(.W(AW + WORD_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (start),
        .push    (push),
        .pop     (im_we && im_ready),
        .wdata   ({next_addr, word}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign im_we     = !fifo_empty;
    assign im_addr   = fifo_head[AW+WORD_W-1:WORD_W];
    assign im_wdata  = fifo_head[WORD_W-1:0];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            next_addr  <= '0;
            last_alloc <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else if (start) begin
            state      <= ST_RUN;
            next_addr  <= '0;
            last_alloc <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hs) begin
                        if (push) begin
                            // Stop at the last address instead of wrapping.
                            if (next_addr == LAST_ADDR) last_alloc <= 1'b1;
                            else                        next_addr  <= next_addr + 1'b1;
                        end else begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end
                    // Enter FULL only after the last word has drained to memory.
                    if (last_alloc && fifo_empty) begin
                        state <= ST_FULL;
                        full  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import cpu19_pkg::*;

    localparam int AW = 8;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    op;
    logic [4:0]    funct5;
    logic [2:0]    rd;
    logic [2:0]    rs1;
    logic [2:0]    rs2;
    logic [10:0]   imm;
    logic          im_we;
    logic          im_ready;
    logic [AW-1:0] im_addr;
    logic [18:0]   im_wdata;
    logic          full;
    logic          err;
    logic [7:0]    err_count;
    enc_state_t    dbg_state;

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW+18:0] exp_q[$];
    logic [AW-1:0]  m_addr;
    logic           m_last;
    int             m_errs;
    bit             rand_ready = 1'b0;

    instr_encoder #(.AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct5    (funct5),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .im_we     (im_we),
        .im_ready  (im_ready),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .full      (full),
        .err       (err),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // Clock, and a watchdog that stops a run that hangs.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference packing, written out directly from the field layouts.
    function automatic logic [18:0] model_word(input logic [4:0] o, input logic [4:0] f,
                                               input logic [2:0] d, input logic [2:0] s1,
                                               input logic [2:0] s2, input logic [10:0] im);
        case (o)
            OP_ALU:           return {s2, s1, f, d, o};
            OP_LOAD, OP_ALUI: return {im[2:0], s1, f, d, o};
            OP_BRANCH:        return {3'b000, s1, im[4:0], s2, o};
            default:          return {im, d, o};
        endcase
    endfunction

    function automatic bit model_legal(input logic [4:0] o, input logic [10:0] im);
        int v;
        v = int'($signed(im));
        case (o)
            OP_ALU, OP_JAL:   return 1'b1;
            OP_LOAD, OP_ALUI: return !RANGE_CHECK || (v >= -4 && v <= 3);
            OP_BRANCH:        return !RANGE_CHECK || (v >= -16 && v <= 15);
            default:          return 1'b0;
        endcase
    endfunction

    // Scoreboard: check the head against the model on every cycle im_we is high.
    // This also covers hold stability during stalls. Pop when the write completes.
    initial begin
        forever begin
            @(negedge clk);
            if (im_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(im_addr), 32'hFFFF_FFFF);
                end else begin
                    check(im_ready ? "write" : "stall_hold", 32'({im_addr, im_wdata}), 32'(exp_q[0]));
                    if (im_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Random back-pressure, changed away from both clock edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) im_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Driver tasks. Each is called, and returns, at posedge + 1.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_addr = '0;
        m_last = 1'b0;
        m_errs = 0;
    endtask

    task automatic send(input logic [4:0] o, input logic [4:0] f, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [10:0] im);
        int waited;
        waited = 0;
        op = o; funct5 = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (model_legal(o, im)) begin
            exp_q.push_back({m_addr, model_word(o, f, d, s1, s2, im)});
            if (m_addr == {AW{1'b1}}) m_last = 1'b1;
            else                      m_addr = m_addr + 1'b1;
        end else if (m_errs < 255) begin
            m_errs++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_im_we"},     32'(im_we),     32'd0);
        check({tag, "_im_addr"},   32'(im_addr),   32'd0);
        check({tag, "_im_wdata"},  32'(im_wdata),  32'd0);
        check({tag, "_full"},      32'(full),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [10:0] rv;
        logic [4:0]  ro;

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; im_ready = 1'b1;
        op = '0; funct5 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        m_addr = '0; m_last = 1'b0; m_errs = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // R-op: check the word layout, and that im_we rises one cycle after the transfer.
        do_start();
        check("run_state", 32'(dbg_state), 32'(ST_RUN));
        send(OP_ALU, 5'h10, 3'd1, 3'd2, 3'd3, 11'd0);
        check("latency_we", 32'(im_we), 32'd1);
        check("r_word", 32'(im_wdata), 32'({3'd3, 3'd2, 5'h10, 3'd1, OP_ALU}));
        drain();

        // I-op with imm=4: rejected when the range check is enabled, truncated otherwise.
        do_start();
        send(OP_ALUI, 5'h01, 3'd4, 3'd5, 3'd0, 11'd4);
        check("i_err", 32'(err), RANGE_CHECK ? 32'd1 : 32'd0);
        check("i_err_count", 32'(err_count), RANGE_CHECK ? 32'd1 : 32'd0);
        send(OP_ALU, 5'h03, 3'd7, 3'd6, 3'd5, 11'd0);
        drain();

        // Burst of three words into a stalled memory.
        do_start();
        im_ready = 1'b0;
        send(OP_ALU,  5'h01, 3'd1, 3'd1, 3'd1, 11'd0);
        send(OP_LOAD, 5'h02, 3'd2, 3'd3, 3'd0, 11'h7FC);
        @(negedge clk);
        check("burst_in_ready_low", 32'(in_ready), 32'd0);
        check("burst_im_we", 32'(im_we), 32'd1);
        check("burst_head_addr", 32'(im_addr), 32'd0);
        @(posedge clk);
        #1;
        fork
            send(OP_JAL, 5'h00, 3'd4, 3'd0, 3'd0, 11'h155);
            begin
                repeat (5) @(posedge clk);
                #2;
                im_ready = 1'b1;
            end
        join
        drain();

        // Immediate boundaries in each format, then a random mix.
        send(OP_JAL, 5'h00, 3'd6, 3'd0, 3'd0, 11'h400);
        send(OP_BRANCH, 5'h00, 3'd2, 3'd5, 3'd7, 11'h7F0);
        send(OP_BRANCH, 5'h00, 3'd1, 3'd2, 3'd3, 11'd15);
        send(OP_BRANCH, 5'h00, 3'd1, 3'd2, 3'd3, 11'd16);
        send(OP_ALUI, 5'h1F, 3'd3, 3'd4, 3'd0, 11'd3);
        send(OP_LOAD, 5'h00, 3'd3, 3'd4, 3'd0, 11'h7FB);
        drain();
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       ro = OP_LOAD;
                1:       ro = OP_ALUI;
                2:       ro = OP_ALU;
                3:       ro = OP_BRANCH;
                4:       ro = OP_JAL;
                default: ro = 5'h1F;
            endcase
            rv = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) rv = {{8{rv[2]}}, rv[2:0]};
            send(ro, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rv);
        end
        rand_ready = 1'b0;
        im_ready = 1'b1;
        drain();
        check("rand_err_count", 32'(err_count), 32'(m_errs));

        // err_count saturates at 255.
        do_start();
        check("start_clears_err", 32'(err), 32'd0);
        for (int i = 0; i < 257; i++) begin
            send(5'h1F, 5'h00, 3'd0, 3'd0, 3'd0, 11'd0);
            if (i == 0) check("first_reject_count", 32'(err_count), 32'd1);
        end
        check("sat_err_count", 32'(err_count), 32'd255);
        check("sat_err", 32'(err), 32'd1);
        drain();

        // Fill every address, then check that FULL blocks further bundles.
        do_start();
        for (int i = 0; i < 256; i++) begin
            send(OP_ALU, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 11'd0);
        end
        @(negedge clk);
        check("last_alloc_in_ready", 32'(in_ready), 32'd0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("full_flag", 32'(full), 32'd1);
        check("full_state", 32'(dbg_state), 32'(ST_FULL));
        in_valid = 1'b1;
        op = OP_ALU;
        repeat (10) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_no_write", 32'(im_we), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Reset with two words buffered, then restart.
        do_start();
        im_ready = 1'b0;
        send(5'h1F, 5'h00, 3'd0, 3'd0, 3'd0, 11'd0);
        send(OP_ALU, 5'h0A, 3'd5, 3'd6, 3'd7, 11'd0);
        send(OP_JAL, 5'h00, 3'd2, 3'd0, 3'd0, 11'h3FF);
        check("pre_reset_err", 32'(err), 32'd1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        im_ready = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        send(OP_ALU, 5'h11, 3'd3, 3'd1, 3'd2, 11'd0);
        check("restart_addr", 32'(im_addr), 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
